ibex_dummy_reseed_ctrl: RTL

IBEX_DUMMY_RESEED_CTRL -- requirements
Module: ibex_dummy_reseed_ctrl

---
 rtl/ibex_dummy_reseed_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ibex_dummy_reseed_ctrl.sv
// ibex_dummy_reseed_ctrl
//
// Purpose: decides when the dummy-instruction LFSR gets a new seed. It counts
// accepted dummy instructions and, once a programmable interval is reached,
// requests a fresh entropy word. It forwards that word (or a CSR-written seed)
// to the LFSR as a registered one-cycle seed strobe.
//
// Ports:
//   clk_i              sole clock, rising edge
//   rst_i              synchronous active-high reset
//   dummy_instr_en_i   dummy instruction insertion enabled
//   dummy_insert_i     one pulse per accepted dummy instruction
//   reseed_interval_i  accepted dummies between automatic reseeds (0 = off)
//   csr_seed_en_i      CSR seed write strobe
//   csr_seed_i         CSR seed value
//   entropy_req_o      entropy request, held while waiting
//   entropy_ack_i      single-cycle ack, entropy_i valid in the same cycle
//   entropy_i          fresh entropy word
//   seed_en_o          one-cycle LFSR seed strobe
//   seed_o             seed value, holds the last seed between strobes
//   reseed_busy_o      high while an entropy request is outstanding
//   entropy_timeout_o  one-cycle pulse when the entropy wait gives up
module ibex_dummy_reseed_ctrl #(
  parameter int unsigned CntW          = 16,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dummy_instr_en_i,
  input  logic            dummy_insert_i,
  input  logic [CntW-1:0] reseed_interval_i,
  input  logic            csr_seed_en_i,
  input  logic [31:0]     csr_seed_i,
  output logic            entropy_req_o,
  input  logic            entropy_ack_i,
  input  logic [31:0]     entropy_i,
  output logic            seed_en_o,
  output logic [31:0]     seed_o,
  output logic            reseed_busy_o,
  output logic            entropy_timeout_o
);

  // Wide enough to hold TimeoutCycles-1 for any TimeoutCycles >= 1.
  localparam int unsigned WaitW = $clog2(TimeoutCycles + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              seed_en_q, seed_en_d;
  logic [31:0]       seed_q, seed_d;
  logic              timeout_q, timeout_d;

  // One extra bit so the increment and compare can never wrap.
  logic [CntW:0]     cnt_inc;
  logic              auto_on;

  assign cnt_inc = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};
  assign auto_on = dummy_instr_en_i && (reseed_interval_i != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    seed_en_d = 1'b0;
    seed_d    = seed_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        wait_d = '0;
        if (auto_on && dummy_insert_i) begin
          // >= so that lowering the interval below the current count
          // triggers on the very next insert.
          if (cnt_inc >= {1'b0, reseed_interval_i}) begin
            state_d = StReq;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[CntW-1:0];
          end
        end
      end
      StReq: begin
        if (entropy_ack_i) begin
          seed_en_d = 1'b1;
          seed_d    = entropy_i;
          state_d   = StHold;
          wait_d    = '0;
        end else if (!dummy_instr_en_i) begin
          state_d = StIdle;
          wait_d  = '0;
        end else if (wait_q == WaitLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
          wait_d    = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StHold: begin
        // Guarantees the request line is low for at least one cycle.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A CSR seed write overrides everything: it wins over a same-cycle ack,
    // aborts an outstanding request and restarts the interval count.
    if (csr_seed_en_i) begin
      seed_en_d = 1'b1;
      seed_d    = csr_seed_i;
      cnt_d     = '0;
      wait_d    = '0;
      timeout_d = 1'b0;
      state_d   = (state_q == StReq) ? StHold : StIdle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wait_q    <= '0;
      seed_en_q <= 1'b0;
      seed_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      seed_en_q <= seed_en_d;
      seed_q    <= seed_d;
      timeout_q <= timeout_d;
    end
  end

  assign entropy_req_o     = (state_q == StReq);
  assign reseed_busy_o     = (state_q == StReq);
  assign seed_en_o         = seed_en_q;
  assign seed_o            = seed_q;
  assign entropy_timeout_o = timeout_q;

endmodule
